// File: rtl/lsu_bus_arbiter_pkg.sv
// Shared types and address map for the LSU bus arbiter.
// The address map constants are also used by the LSU read-data mux, so
// region decode lives here as a single function that every user calls.
//   region_e    : decoded bus region (REG_NONE = unmapped)
//   arb_state_e : arbiter FSM state, exported for debug
//   master_e    : requester identity (M0 = core LSU, M1 = debug/loader)
package lsu_pkg;

  localparam int LSU_AW = 16;
  localparam int LSU_DW = 32;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_DMEM = 2'd1,
    REG_OP   = 2'd2,
    REG_IP   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } master_e;

  // Region = (addr & MASK) == BASE.
  // DMEM 0x2000-0x3FFF : addr[15:13] == 3'b001
  // OP   0x7000-0x703F : addr[15:6]  == 10'b0111_0000_00
  // IP   0x7800-0x781F : addr[15:5]  == 11'b0111_1000_000
  localparam logic [LSU_AW-1:0] DMEM_BASE = 16'h2000;
  localparam logic [LSU_AW-1:0] DMEM_MASK = 16'hE000;
  localparam logic [LSU_AW-1:0] OP_BASE   = 16'h7000;
  localparam logic [LSU_AW-1:0] OP_MASK   = 16'hFFC0;
  localparam logic [LSU_AW-1:0] IP_BASE   = 16'h7800;
  localparam logic [LSU_AW-1:0] IP_MASK   = 16'hFFE0;

  function automatic logic addr_in_region(input logic [LSU_AW-1:0] addr,
                                          input logic [LSU_AW-1:0] base,
                                          input logic [LSU_AW-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/lsu_bus_arbiter_if.sv
// Bundle of the requester handshakes and the slave-side bus of the LSU
// bus arbiter.
//   i_m0_* / i_m1_*  : requester commands (req, we, addr, wdata, bmask)
//   o_m0_* / o_m1_*  : gnt pulse, rvalid pulse, err, rdata
//   o_bus_* / o_sel_*: latched command and one-hot region selects to slaves
//   i_rd_*           : slave read data, valid one cycle after the select
//
// Handshake: a requester raises req together with its command and holds
// both unchanged until it sees gnt (one-cycle pulse). The response follows
// as a one-cycle rvalid pulse on the next cycle; err qualifies rvalid.
// A requester may raise a new req during its own rvalid cycle.
//
// Modports:
//   master : the environment (requesters and slaves) that drives i_* signals
//   slave  : the arbiter, which answers requesters and drives the bus
interface lsu_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          i_m0_req;
  logic          i_m0_we;
  logic [AW-1:0] i_m0_addr;
  logic [DW-1:0] i_m0_wdata;
  logic [3:0]    i_m0_bmask;
  logic          o_m0_gnt;
  logic          o_m0_rvalid;
  logic          o_m0_err;
  logic [DW-1:0] o_m0_rdata;

  logic          i_m1_req;
  logic          i_m1_we;
  logic [AW-1:0] i_m1_addr;
  logic [DW-1:0] i_m1_wdata;
  logic [3:0]    i_m1_bmask;
  logic          o_m1_gnt;
  logic          o_m1_rvalid;
  logic          o_m1_err;
  logic [DW-1:0] o_m1_rdata;

  logic [AW-1:0] o_bus_addr;
  logic [DW-1:0] o_bus_wdata;
  logic [3:0]    o_bus_bmask;
  logic          o_bus_we;
  logic          o_sel_dmem;
  logic          o_sel_op;
  logic          o_sel_ip;
  logic [DW-1:0] i_rd_data;
  logic [DW-1:0] i_rd_op_data;
  logic [DW-1:0] i_rd_ip_data;

  modport master (
    output i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask,
    input  o_m0_gnt, o_m0_rvalid, o_m0_err, o_m0_rdata,
    output i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask,
    input  o_m1_gnt, o_m1_rvalid, o_m1_err, o_m1_rdata,
    input  o_bus_addr, o_bus_wdata, o_bus_bmask, o_bus_we,
    input  o_sel_dmem, o_sel_op, o_sel_ip,
    output i_rd_data, i_rd_op_data, i_rd_ip_data
  );

  modport slave (
    input  i_m0_req, i_m0_we, i_m0_addr, i_m0_wdata, i_m0_bmask,
    output o_m0_gnt, o_m0_rvalid, o_m0_err, o_m0_rdata,
    input  i_m1_req, i_m1_we, i_m1_addr, i_m1_wdata, i_m1_bmask,
    output o_m1_gnt, o_m1_rvalid, o_m1_err, o_m1_rdata,
    output o_bus_addr, o_bus_wdata, o_bus_bmask, o_bus_we,
    output o_sel_dmem, o_sel_op, o_sel_ip,
    input  i_rd_data, i_rd_op_data, i_rd_ip_data
  );

endinterface

// File: rtl/lsu_bus_arbiter_addr_decode.sv
// lsu_addr_decode: combinational byte address -> bus region.
//   addr   in  16  byte address
//   region out     REG_DMEM / REG_OP / REG_IP, or REG_NONE when unmapped
// The three windows are disjoint, so the priority order has no effect on
// the result; it only keeps the logic a simple mux chain.
module lsu_addr_decode
  import lsu_pkg::*;
(
  input  logic [LSU_AW-1:0] addr,
  output region_e           region
);

  always_comb begin
    region = REG_NONE;
    if (addr_in_region(addr, DMEM_BASE, DMEM_MASK)) begin
      region = REG_DMEM;
    end else if (addr_in_region(addr, OP_BASE, OP_MASK)) begin
      region = REG_OP;
    end else if (addr_in_region(addr, IP_BASE, IP_MASK)) begin
      region = REG_IP;
    end
  end

endmodule

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: shares the 16-bit LSU bus between the core LSU (M0)
// and the debug/loader port (M1).
//   i_clk        in   rising-edge clock
//   i_reset      in   asynchronous, active-low reset
//   bus          if   lsu_bus_arbiter_if.slave (requesters + slave bus)
//   o_dbg_state  out  current FSM state
//
// One transaction every three cycles: IDLE picks a winner and latches its
// command and decoded region, ACCESS pulses gnt and drives the region
// select, RESP returns the slave data (valid one cycle after the select)
// with a one-cycle rvalid. Unmapped addresses get no select and no write
// strobe, only an rvalid with err=1 and zero data.
// Ties go to the master that was not served last; rr_last resets to M1 so
// M0 wins the first tie after reset.
module lsu_bus_arbiter
  import lsu_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lsu_bus_arbiter_if.slave    bus,
  output arb_state_e          o_dbg_state
);

  arb_state_e state_q, state_d;

  // Latched command of the transaction in flight
  master_e       owner_q;
  master_e       rr_last_q;
  region_e       region_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    bmask_q;

  // Arbitration result and the winner's command
  logic          any_req;
  master_e       win;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic [3:0]    win_bmask;
  region_e       win_region;

  // Response data before steering to the owner
  logic [DW-1:0] rd_mux;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  assign any_req = bus.i_m0_req | bus.i_m1_req;

  always_comb begin
    win = MST_M0;
    if (bus.i_m0_req && bus.i_m1_req) begin
      win = (rr_last_q == MST_M1) ? MST_M0 : MST_M1;
    end else if (bus.i_m1_req) begin
      win = MST_M1;
    end
  end

  always_comb begin
    win_we    = bus.i_m0_we;
    win_addr  = bus.i_m0_addr;
    win_wdata = bus.i_m0_wdata;
    win_bmask = bus.i_m0_bmask;
    if (win == MST_M1) begin
      win_we    = bus.i_m1_we;
      win_addr  = bus.i_m1_addr;
      win_wdata = bus.i_m1_wdata;
      win_bmask = bus.i_m1_bmask;
    end
  end

  // Decode at arbitration time so ACCESS drives selects straight from a flop
  lsu_addr_decode u_addr_decode (
    .addr   (win_addr),
    .region (win_region)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Command latch and round-robin pointer
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      owner_q   <= MST_M0;
      rr_last_q <= MST_M1;
      region_q  <= REG_NONE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bmask_q   <= '0;
    end else begin
      if (state_q == S_IDLE && any_req) begin
        owner_q  <= win;
        region_q <= win_region;
        we_q     <= win_we;
        addr_q   <= win_addr;
        wdata_q  <= win_wdata;
        bmask_q  <= win_bmask;
      end
      // The pointer only moves once the response is delivered, so a
      // transaction cut short by reset never counts as a turn.
      if (state_q == S_RESP) begin
        rr_last_q <= owner_q;
      end
    end
  end

  // Slave read-data mux, sampled in RESP (one cycle after the select)
  always_comb begin
    rd_mux = '0;
    case (region_q)
      REG_DMEM: rd_mux = bus.i_rd_data;
      REG_OP:   rd_mux = bus.i_rd_op_data;
      REG_IP:   rd_mux = bus.i_rd_ip_data;
      default:  rd_mux = '0;
    endcase
  end

  // Writes and unmapped accesses return zero data
  assign resp_err   = (region_q == REG_NONE);
  assign resp_rdata = we_q ? '0 : rd_mux;

  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wdata = wdata_q;
  assign bus.o_bus_bmask = bmask_q;

  // State-decoded outputs; all of them fall with state_q on reset, which
  // is what makes the strobes drop asynchronously.
  always_comb begin
    bus.o_m0_gnt    = 1'b0;
    bus.o_m1_gnt    = 1'b0;
    bus.o_m0_rvalid = 1'b0;
    bus.o_m1_rvalid = 1'b0;
    bus.o_m0_err    = 1'b0;
    bus.o_m1_err    = 1'b0;
    bus.o_m0_rdata  = '0;
    bus.o_m1_rdata  = '0;
    bus.o_bus_we    = 1'b0;
    bus.o_sel_dmem  = 1'b0;
    bus.o_sel_op    = 1'b0;
    bus.o_sel_ip    = 1'b0;
    case (state_q)
      S_ACCESS: begin
        bus.o_m0_gnt   = (owner_q == MST_M0);
        bus.o_m1_gnt   = (owner_q == MST_M1);
        bus.o_sel_dmem = (region_q == REG_DMEM);
        bus.o_sel_op   = (region_q == REG_OP);
        bus.o_sel_ip   = (region_q == REG_IP);
        bus.o_bus_we   = we_q && (region_q != REG_NONE);
      end
      S_RESP: begin
        if (owner_q == MST_M0) begin
          bus.o_m0_rvalid = 1'b1;
          bus.o_m0_err    = resp_err;
          bus.o_m0_rdata  = resp_rdata;
        end else begin
          bus.o_m1_rvalid = 1'b1;
          bus.o_m1_err    = resp_err;
          bus.o_m1_rdata  = resp_rdata;
        end
      end
      default: ;
    endcase
  end

  assign o_dbg_state = state_q;

  // Protocol checks

  // The response path is built for a single-cycle slave read latency and a
  // 16-bit address map.
  a_rd_lat_one: assert property (@(posedge i_clk) RD_LAT == 1);
  a_aw_sixteen: assert property (@(posedge i_clk) AW == LSU_AW);

  // A requester keeps req up until it has been granted.
  a_m0_req_held: assert property (@(posedge i_clk) disable iff (!i_reset)
    bus.i_m0_req && !bus.o_m0_gnt |=> bus.i_m0_req);
  a_m1_req_held: assert property (@(posedge i_clk) disable iff (!i_reset)
    bus.i_m1_req && !bus.o_m1_gnt |=> bus.i_m1_req);

  a_sel_onehot: assert property (@(posedge i_clk) disable iff (!i_reset)
    $onehot0({bus.o_sel_dmem, bus.o_sel_op, bus.o_sel_ip}));
  a_gnt_excl: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(bus.o_m0_gnt && bus.o_m1_gnt));
  a_rvalid_excl: assert property (@(posedge i_clk) disable iff (!i_reset)
    !(bus.o_m0_rvalid && bus.o_m1_rvalid));

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
module tb_lsu_bus_arbiter;
  import lsu_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SB_W = 2 + DW;  // {master, err, rdata}

  // ---------------- clock / reset ----------------
  logic i_clk;
  logic i_reset;
  arb_state_e dbg_state;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  lsu_bus_arbiter_if #(.AW(AW), .DW(DW)) bus_if ();

  lsu_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [SB_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- slave models (read latency 1) ----------------
  logic [DW-1:0] slv_dmem, slv_op, slv_ip;

  always @(posedge i_clk) begin
    bus_if.i_rd_data    <= bus_if.o_sel_dmem ? slv_dmem : 32'hFFFF_FFFF;
    bus_if.i_rd_op_data <= bus_if.o_sel_op   ? slv_op   : 32'hFFFF_FFFF;
    bus_if.i_rd_ip_data <= bus_if.o_sel_ip   ? slv_ip   : 32'hFFFF_FFFF;
  end

  // ---------------- response monitor ----------------
  always @(negedge i_clk) begin
    logic [SB_W-1:0] exp_item;
    logic [SB_W-1:0] act_item;
    if (bus_if.o_m0_rvalid || bus_if.o_m1_rvalid) begin
      check("rvalid_exclusive", {63'd0, bus_if.o_m0_rvalid & bus_if.o_m1_rvalid}, 64'd0);
      act_item = bus_if.o_m1_rvalid ? {1'b1, bus_if.o_m1_err, bus_if.o_m1_rdata}
                                    : {1'b0, bus_if.o_m0_err, bus_if.o_m0_rdata};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_rvalid: got 0x%0h, expected no response", act_item);
      end else begin
        exp_item = exp_q.pop_front();
        check("response", {30'd0, act_item}, {30'd0, exp_item});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_master(input bit m, input bit req, input bit we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [3:0] bmask);
    if (m == 1'b0) begin
      bus_if.i_m0_req   = req;
      bus_if.i_m0_we    = we;
      bus_if.i_m0_addr  = addr;
      bus_if.i_m0_wdata = wdata;
      bus_if.i_m0_bmask = bmask;
    end else begin
      bus_if.i_m1_req   = req;
      bus_if.i_m1_we    = we;
      bus_if.i_m1_addr  = addr;
      bus_if.i_m1_wdata = wdata;
      bus_if.i_m1_bmask = bmask;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_master(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 10; c++) begin
      if (exp_q.size() == 0) break;
      @(negedge i_clk);
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit            m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    bmask;
    logic [DW-1:0] rdval;      // what every slave returns when selected
    logic [2:0]    exp_sel;    // {ip, op, dmem}
    bit            exp_we;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs[NVEC];

  // Caller is at a negedge with the FSM in IDLE; returns at the negedge of
  // the following IDLE cycle.
  task automatic apply_vec(input vec_t v, input int idx);
    int  c;
    bit  got;
    bit  gnt;
    bit  other_gnt;
    bit  rv;
    slv_dmem = v.rdval;
    slv_op   = v.rdval;
    slv_ip   = v.rdval;
    drive_master(v.m, 1'b1, v.we, v.addr, v.wdata, v.bmask);
    exp_q.push_back({v.m, v.exp_err, v.exp_rdata});
    got = 1'b0;
    c = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      gnt = v.m ? bus_if.o_m1_gnt : bus_if.o_m0_gnt;
      if (gnt) begin
        got = 1'b1;
        c = k;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL vec%0d_gnt_timeout: got no gnt in 8 cycles, expected gnt", idx);
      drive_master(v.m, 1'b0, 1'b0, '0, '0, '0);
      exp_q.delete();
      do_reset();
      return;
    end
    other_gnt = v.m ? bus_if.o_m0_gnt : bus_if.o_m1_gnt;
    check($sformatf("vec%0d_gnt_latency", idx), c, 0);
    check($sformatf("vec%0d_other_gnt", idx), other_gnt, 0);
    check($sformatf("vec%0d_state_access", idx), dbg_state, S_ACCESS);
    check($sformatf("vec%0d_sel", idx),
          {bus_if.o_sel_ip, bus_if.o_sel_op, bus_if.o_sel_dmem}, v.exp_sel);
    check($sformatf("vec%0d_bus_we", idx), bus_if.o_bus_we, v.exp_we);
    check($sformatf("vec%0d_bus_cmd", idx),
          {bus_if.o_bus_addr, bus_if.o_bus_wdata, bus_if.o_bus_bmask},
          {v.addr, v.wdata, v.bmask});
    @(negedge i_clk);
    rv = v.m ? bus_if.o_m1_rvalid : bus_if.o_m0_rvalid;
    check($sformatf("vec%0d_rvalid", idx), rv, 1);
    check($sformatf("vec%0d_sel_off_in_resp", idx),
          {bus_if.o_sel_ip, bus_if.o_sel_op, bus_if.o_sel_dmem, bus_if.o_bus_we}, 0);
    drive_master(v.m, 1'b0, 1'b0, '0, '0, '0);
    @(negedge i_clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    int g0, g1, n_g, last_g;
    bit drop0, drop1, exp_m, g;

    //           m   we  addr      wdata         bmask  rdval         sel     we  err rdata
    vecs[0]  = '{0, 0, 16'h2004, 32'h0,         4'hF, 32'hDEADBEEF, 3'b001, 0, 0, 32'hDEADBEEF};
    vecs[1]  = '{1, 0, 16'h5000, 32'h0,         4'hF, 32'h13579BDF, 3'b000, 0, 1, 32'h0};
    vecs[2]  = '{0, 0, 16'h3FFC, 32'h0,         4'hF, 32'h12345678, 3'b001, 0, 0, 32'h12345678};
    vecs[3]  = '{1, 0, 16'h703C, 32'h0,         4'hF, 32'hCAFE0001, 3'b010, 0, 0, 32'hCAFE0001};
    vecs[4]  = '{0, 0, 16'h7040, 32'h0,         4'hF, 32'h24682468, 3'b000, 0, 1, 32'h0};
    vecs[5]  = '{1, 0, 16'h781C, 32'h0,         4'hF, 32'h0BADF00D, 3'b100, 0, 0, 32'h0BADF00D};
    vecs[6]  = '{0, 0, 16'h7820, 32'h0,         4'hF, 32'h77777777, 3'b000, 0, 1, 32'h0};
    vecs[7]  = '{0, 1, 16'h7000, 32'hA5A5A5A5,  4'h3, 32'h99999999, 3'b010, 1, 0, 32'h0};
    vecs[8]  = '{1, 1, 16'h2000, 32'h00000011,  4'hF, 32'h88888888, 3'b001, 1, 0, 32'h0};
    vecs[9]  = '{1, 1, 16'h1FFC, 32'h00000022,  4'h1, 32'h66666666, 3'b000, 0, 1, 32'h0};
    vecs[10] = '{0, 0, 16'h7800, 32'h0,         4'hF, 32'h00C0FFEE, 3'b100, 0, 0, 32'h00C0FFEE};
    vecs[11] = '{1, 0, 16'h6FFC, 32'h0,         4'hF, 32'h55555555, 3'b000, 0, 1, 32'h0};

    slv_dmem = '0;
    slv_op   = '0;
    slv_ip   = '0;
    i_reset  = 1'b0;
    drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_master(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(negedge i_clk);

    // Reset state
    check("reset_state", dbg_state, S_IDLE);
    check("reset_handshake",
          {bus_if.o_m0_gnt, bus_if.o_m0_rvalid, bus_if.o_m0_err,
           bus_if.o_m1_gnt, bus_if.o_m1_rvalid, bus_if.o_m1_err}, 0);
    check("reset_strobes",
          {bus_if.o_bus_we, bus_if.o_sel_dmem, bus_if.o_sel_op, bus_if.o_sel_ip}, 0);
    check("reset_bus_cmd", {bus_if.o_bus_addr, bus_if.o_bus_wdata, bus_if.o_bus_bmask}, 0);
    check("reset_rdata", {bus_if.o_m0_rdata, bus_if.o_m1_rdata}, 0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("idle_no_req", dbg_state, S_IDLE);

    // Single-requester vectors: decode, boundaries, errors, writes
    for (int i = 0; i < NVEC; i++) begin
      apply_vec(vecs[i], i);
    end
    wait_drain();

    // Simultaneous request after reset: M0 first, M1 three cycles later
    do_reset();
    slv_dmem = 32'h0A0B0C0D;
    slv_op   = 32'h0F0F0F0F;
    slv_ip   = 32'h0E0E0E0E;
    drive_master(1'b0, 1'b1, 1'b0, 16'h2008, 32'h0, 4'hF);
    drive_master(1'b1, 1'b1, 1'b1, 16'h7010, 32'h55, 4'hF);
    exp_q.push_back({1'b0, 1'b0, 32'h0A0B0C0D});
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    g0 = 0; g1 = 0; drop0 = 0; drop1 = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge i_clk);
      if (drop0) begin drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0); drop0 = 0; end
      if (drop1) begin drive_master(1'b1, 1'b0, 1'b0, '0, '0, '0); drop1 = 0; end
      if (bus_if.o_m0_gnt) begin
        g0 = cyc;
        drop0 = 1;
        check("tie_m0_sel", {bus_if.o_sel_ip, bus_if.o_sel_op, bus_if.o_sel_dmem, bus_if.o_bus_we},
              4'b0010);
      end
      if (bus_if.o_m1_gnt) begin
        g1 = cyc;
        drop1 = 1;
        check("tie_m1_strobes",
              {bus_if.o_sel_ip, bus_if.o_sel_op, bus_if.o_sel_dmem, bus_if.o_bus_we}, 4'b0101);
        check("tie_m1_cmd", {bus_if.o_bus_addr, bus_if.o_bus_wdata}, {16'h7010, 32'h55});
      end
    end
    check("tie_m0_gnt_cycle", g0, 1);
    check("tie_m1_gnt_cycle", g1, 4);
    wait_drain();

    // Both requesters held: grants alternate M0,M1,... three cycles apart
    do_reset();
    slv_dmem = 32'h11112222;
    slv_op   = 32'hFFFF0000;
    slv_ip   = 32'h33334444;
    drive_master(1'b0, 1'b1, 1'b0, 16'h2010, 32'h0, 4'hF);
    drive_master(1'b1, 1'b1, 1'b0, 16'h7804, 32'h0, 4'hF);
    n_g = 0; last_g = -1; exp_m = 1'b0; drop0 = 0; drop1 = 0;
    for (int cyc = 1; cyc <= 20 && n_g < 5; cyc++) begin
      @(negedge i_clk);
      if (drop0) begin drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0); drop0 = 0; end
      if (drop1) begin drive_master(1'b1, 1'b0, 1'b0, '0, '0, '0); drop1 = 0; end
      if (bus_if.o_m0_gnt || bus_if.o_m1_gnt) begin
        g = bus_if.o_m1_gnt;
        check("rr_gnt_exclusive", {bus_if.o_m0_gnt, bus_if.o_m1_gnt} == 2'b11, 0);
        check($sformatf("rr_order_%0d", n_g), g, exp_m);
        if (last_g >= 0) check($sformatf("rr_gap_%0d", n_g), cyc - last_g, 3);
        exp_q.push_back({g, 1'b0, g ? 32'h33334444 : 32'h11112222});
        last_g = cyc;
        n_g++;
        exp_m = ~exp_m;
        if (n_g >= 4) begin
          if (g) drop1 = 1; else drop0 = 1;
        end
      end
    end
    check("rr_grant_count", n_g, 5);
    @(negedge i_clk);
    drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_master(1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_drain();
    @(negedge i_clk);

    // Reset during ACCESS aborts the transaction without a response
    slv_dmem = 32'hDEADBEEF;
    drive_master(1'b0, 1'b1, 1'b0, 16'h2004, 32'h0, 4'hF);
    @(negedge i_clk);
    check("abort_pre_gnt", {bus_if.o_m0_gnt, bus_if.o_sel_dmem}, 2'b11);
    #2;
    i_reset = 1'b0;
    #1;
    check("abort_strobes_drop",
          {bus_if.o_m0_gnt, bus_if.o_m1_gnt, bus_if.o_sel_dmem, bus_if.o_sel_op,
           bus_if.o_sel_ip, bus_if.o_bus_we}, 0);
    check("abort_state", dbg_state, S_IDLE);
    drive_master(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) begin
      @(negedge i_clk);
      check("abort_no_rvalid", {bus_if.o_m0_rvalid, bus_if.o_m1_rvalid}, 0);
    end
    i_reset = 1'b1;
    @(negedge i_clk);
    check("abort_no_rvalid_after", {bus_if.o_m0_rvalid, bus_if.o_m1_rvalid}, 0);
    apply_vec(vecs[0], 100);
    apply_vec(vecs[5], 101);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
